// File: rtl/ecc_dec_40_33.sv
// Three-stage SECDED decoder for 40-bit codewords carrying 33 data bits.
// It corrects single-bit errors, flags double-bit errors and keeps saturating event counters.
module ecc_dec_40_33 #(
  parameter bit          PINVERT   = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 din_valid,
  input  logic [39:0]          din,
  output logic                 dout_valid,
  output logic [32:0]          dout,
  output logic                 err_corr,
  output logic                 err_uncorr,
  output logic [6:0]           syndrome,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Returns {S[5:0], E}. Each codeword bit feeds E and every S bit set in its position.
  function automatic logic [6:0] calc_syndrome(input logic [39:0] cw);
    logic [5:0] s;
    logic       e;
    logic [5:0] pos;
    s = {6{PINVERT}};
    e = PINVERT;
    for (int unsigned i = 0; i < 40; i++) begin
      pos = i[5:0];
      e   = e ^ cw[pos];
      s   = s ^ ({6{cw[pos]}} & pos);
    end
    return {s, e};
  endfunction

  // Data occupies every position that is not zero and not a power of two, ascending.
  function automatic logic [32:0] extract_data(input logic [39:0] cw);
    logic [32:0] d;
    logic [5:0]  j;
    d = '0;
    j = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i[5:0]];
        j    = j + 6'd1;
      end
    end
    return d;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [39:0]          s1_cw_q, s1_cw_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [39:0]          s2_cw_q, s2_cw_d;
  logic [6:0]           s2_syn_q, s2_syn_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [32:0]          dout_q, dout_d;
  logic                 err_corr_q, err_corr_d;
  logic                 err_uncorr_q, err_uncorr_d;
  logic [6:0]           syndrome_q, syndrome_d;
  logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_WIDTH-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic [5:0]  s3_s;
  logic        s3_e;
  logic        fix_corr;
  logic        fix_uncorr;
  logic [39:0] cw_fixed;

  always_comb begin
    s1_valid_d = din_valid;
    s1_cw_d    = din;

    s2_valid_d = s1_valid_q;
    s2_cw_d    = s1_cw_q;
    s2_syn_d   = calc_syndrome(s1_cw_q);

    s3_s       = s2_syn_q[6:1];
    s3_e       = s2_syn_q[0];
    fix_corr   = s3_e && (s3_s <= 6'd39);
    fix_uncorr = (s3_e && (s3_s >= 6'd40)) || (!s3_e && (s3_s != '0));
    // Position 0 is the overall parity bit, so S==0 with E==1 flips only p0.
    cw_fixed   = fix_corr ? (s2_cw_q ^ (40'd1 << s3_s)) : s2_cw_q;

    dout_valid_d = s2_valid_q;
    dout_d       = extract_data(cw_fixed);
    err_corr_d   = s2_valid_q & fix_corr;
    err_uncorr_d = s2_valid_q & fix_uncorr;
    syndrome_d   = s2_valid_q ? s2_syn_q : '0;

    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (dout_valid_q && err_corr_q && (corr_cnt_q != '1))
        corr_cnt_d = corr_cnt_q + CNT_ONE;
      if (dout_valid_q && err_uncorr_q && (uncorr_cnt_q != '1))
        uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid_q   <= 1'b0;
      s1_cw_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_cw_q      <= '0;
      s2_syn_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      syndrome_q   <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_cw_q      <= s1_cw_d;
      s2_valid_q   <= s2_valid_d;
      s2_cw_q      <= s2_cw_d;
      s2_syn_q     <= s2_syn_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      err_corr_q   <= err_corr_d;
      err_uncorr_q <= err_uncorr_d;
      syndrome_q   <= syndrome_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;
  assign syndrome   = syndrome_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc_dec_40_33.sv
// Directed bench for ecc_dec_40_33: vector table decoded back-to-back and gapped,
// plus counter saturation, clear priority and mid-burst reset.
module tb_ecc_dec_40_33;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        din_valid;
  logic [39:0] din;
  logic        cnt_clr;

  logic        dout_valid;
  logic [32:0] dout;
  logic        err_corr;
  logic        err_uncorr;
  logic [6:0]  syndrome;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;

  logic        b_dout_valid;
  logic [32:0] b_dout;
  logic        b_err_corr;
  logic        b_err_uncorr;
  logic [6:0]  b_syndrome;
  logic [1:0]  b_corr_cnt;
  logic [1:0]  b_uncorr_cnt;

  always #5 clk = ~clk;

  ecc_dec_40_33 u_dut (
    .clk(clk), .arst_n(arst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid), .dout(dout), .err_corr(err_corr), .err_uncorr(err_uncorr),
    .syndrome(syndrome), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  ecc_dec_40_33 #(.CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .arst_n(arst_n), .din_valid(din_valid), .din(din),
    .dout_valid(b_dout_valid), .dout(b_dout), .err_corr(b_err_corr), .err_uncorr(b_err_uncorr),
    .syndrome(b_syndrome), .cnt_clr(cnt_clr), .corr_cnt(b_corr_cnt), .uncorr_cnt(b_uncorr_cnt)
  );

  typedef struct {
    logic [39:0] din;
    logic [32:0] dout;
    logic        corr;
    logic        uncorr;
    logic [6:0]  syn;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    din_valid = 1'b0;
    din       = '0;
  endtask

  // gap = number of bubble cycles inserted after every vector
  task automatic run_table(input int gap, input string tag);
    int slots[$];
    slots.delete();
    for (int i = 0; i < NVEC; i++) begin
      slots.push_back(i);
      for (int g = 0; g < gap; g++) slots.push_back(-1);
    end
    for (int c = 0; c < slots.size() + 3; c++) begin
      @(negedge clk);
      if (c >= 3 && slots[c-3] >= 0) begin
        int k;
        k = slots[c-3];
        chk($sformatf("%s v%0d valid", tag, k), 64'(dout_valid), 64'(1'b1));
        chk($sformatf("%s v%0d dout", tag, k), 64'(dout), 64'(vecs[k].dout));
        chk($sformatf("%s v%0d err_corr", tag, k), 64'(err_corr), 64'(vecs[k].corr));
        chk($sformatf("%s v%0d err_uncorr", tag, k), 64'(err_uncorr), 64'(vecs[k].uncorr));
        chk($sformatf("%s v%0d syndrome", tag, k), 64'(syndrome), 64'(vecs[k].syn));
      end else begin
        chk($sformatf("%s bubble%0d valid", tag, c), 64'(dout_valid), 64'(1'b0));
        chk($sformatf("%s bubble%0d flags", tag, c), 64'({err_corr, err_uncorr}), 64'(2'b00));
      end
      if (c < slots.size() && slots[c] >= 0) begin
        din_valid = 1'b1;
        din       = vecs[slots[c]].din;
      end else begin
        drive_idle();
      end
    end
  endtask

  initial begin
    vecs[0] = '{40'h01_0001_0117, 33'h0,           1'b0, 1'b0, 7'h00}; // clean, data 0
    vecs[1] = '{40'h01_0001_011F, 33'h0,           1'b1, 1'b0, 7'h07}; // bit 3 flipped
    vecs[2] = '{40'h01_0001_0116, 33'h0,           1'b1, 1'b0, 7'h01}; // p0 flipped
    vecs[3] = '{40'h01_0001_013F, 33'h3,           1'b0, 1'b1, 7'h0C}; // bits 3,5
    vecs[4] = '{40'h00_0001_0315, 33'h10,          1'b0, 1'b1, 7'h51}; // S=40, E=1
    vecs[5] = '{40'h01_0001_0118, 33'h1,           1'b0, 1'b0, 7'h00}; // clean, data 1
    vecs[6] = '{40'h80_0001_0100, 33'h1_0000_0000, 1'b0, 1'b0, 7'h00}; // clean, data bit 32
    vecs[7] = '{40'h00_0001_0100, 33'h1_0000_0000, 1'b1, 1'b0, 7'h4F}; // bit 39 flipped, S=39
    vecs[8] = '{40'h00_0001_0117, 33'h0,           1'b1, 1'b0, 7'h41}; // p32 flipped

    arst_n  = 1'b1;
    cnt_clr = 1'b0;
    drive_idle();
    #1 arst_n = 1'b0;
    #1;
    chk("reset dout_valid", 64'(dout_valid), 64'(1'b0));
    chk("reset flags", 64'({err_corr, err_uncorr}), 64'(2'b00));
    chk("reset syndrome", 64'(syndrome), 64'(7'h00));
    chk("reset dout", 64'(dout), 64'(33'h0));
    chk("reset counters", 64'({corr_cnt, uncorr_cnt}), 64'(32'h0));
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    run_table(0, "b2b");
    @(negedge clk);
    chk("b2b corr_cnt", 64'(corr_cnt), 64'(16'd4));
    chk("b2b uncorr_cnt", 64'(uncorr_cnt), 64'(16'd2));
    chk("b2b sat corr_cnt", 64'(b_corr_cnt), 64'(2'd3));
    chk("b2b sat uncorr_cnt", 64'(b_uncorr_cnt), 64'(2'd2));

    run_table(1, "gap");
    @(negedge clk);
    chk("gap corr_cnt", 64'(corr_cnt), 64'(16'd8));
    chk("gap uncorr_cnt", 64'(uncorr_cnt), 64'(16'd4));
    chk("gap sat corr_cnt", 64'(b_corr_cnt), 64'(2'd3));
    chk("gap sat uncorr_cnt", 64'(b_uncorr_cnt), 64'(2'd3));

    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr counters", 64'({corr_cnt, uncorr_cnt}), 64'(32'h0));
    chk("clr sat counters", 64'({b_corr_cnt, b_uncorr_cnt}), 64'(4'h0));

    // clear coincides with the cycle a correctable event would be counted
    din_valid = 1'b1;
    din       = vecs[1].din;
    @(negedge clk); drive_idle();
    @(negedge clk);
    @(negedge clk);
    chk("clr+event flag", 64'(err_corr), 64'(1'b1));
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr+event corr_cnt", 64'(corr_cnt), 64'(16'd0));
    @(negedge clk);
    chk("clr+event corr_cnt hold", 64'(corr_cnt), 64'(16'd0));

    din_valid = 1'b1;
    din       = vecs[1].din;
    @(negedge clk); drive_idle();
    repeat (3) @(negedge clk);
    chk("event after clr corr_cnt", 64'(corr_cnt), 64'(16'd1));

    // reset asserted while a burst is streaming
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = vecs[1].din;
    end
    chk("burst pre-reset valid", 64'(dout_valid), 64'(1'b1));
    chk("burst pre-reset corr", 64'(err_corr), 64'(1'b1));
    #2 arst_n = 1'b0;
    #1;
    chk("midreset dout_valid", 64'(dout_valid), 64'(1'b0));
    chk("midreset flags", 64'({err_corr, err_uncorr}), 64'(2'b00));
    chk("midreset syndrome", 64'(syndrome), 64'(7'h00));
    chk("midreset dout", 64'(dout), 64'(33'h0));
    chk("midreset counters", 64'({corr_cnt, uncorr_cnt}), 64'(32'h0));
    drive_idle();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset stale valid %0d", i), 64'(dout_valid), 64'(1'b0));
    end

    din_valid = 1'b1;
    din       = vecs[3].din;
    @(negedge clk); drive_idle();
    chk("first word lat1 valid", 64'(dout_valid), 64'(1'b0));
    @(negedge clk);
    chk("first word lat2 valid", 64'(dout_valid), 64'(1'b0));
    @(negedge clk);
    chk("first word lat3 valid", 64'(dout_valid), 64'(1'b1));
    chk("first word uncorr", 64'(err_uncorr), 64'(1'b1));
    chk("first word dout", 64'(dout), 64'(33'h3));
    @(negedge clk);
    chk("first word uncorr_cnt", 64'(uncorr_cnt), 64'(16'd1));
    chk("first word valid drop", 64'(dout_valid), 64'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
